z16_multicycle_ctrl: RTL and testbench
======================================

Name: z16_multicycle_ctrl

Overview:
Multi-cycle sequencer for the Z16 core. It owns the PC and instruction register (IR), and drives instruction/data memory request handshakes. It presents the latched instruction to the Z16 decoder and uses the decoder's write-enable outputs to steer each instruction through FETCH, DECODE, EXEC, MEM and WB. The register-file write strobe and retire pulse come from this block.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset.
PC_STEP, 16'h0002, PC increment per retired instruction (byte-addressed 16-bit instructions).

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_run  input  1  1 = execute instructions; 0 = park in IDLE after the current instruction
o_imem_req  output  1  instruction fetch request
o_imem_addr  output  16  fetch address (= o_pc)
i_imem_ack  input  1  fetch complete; i_imem_rdata valid this cycle
i_imem_rdata  input  16  fetched instruction
o_instr  output  16  IR contents, fed to decoder
i_rd_wen  input  1  decoder: instruction writes rd
i_mem_wen  input  1  decoder: instruction writes memory
o_dmem_req  output  1  data memory request
o_dmem_we  output  1  1 = store, 0 = load; valid while o_dmem_req = 1
i_dmem_ack  input  1  data access complete
o_rf_we  output  1  register-file write strobe, one cycle
o_retire  output  1  one-cycle pulse as an instruction completes
o_pc  output  16  current PC
o_retire_cnt  output  16  retired-instruction counter
o_state  output  3  FSM state, for debug

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, pc = PC_RESET, IR = 16'h0000, o_retire_cnt = 0.
  - o_imem_req, o_dmem_req, o_dmem_we, o_rf_we and o_retire are all 0.
  - Assertion mid-handshake aborts immediately; no retire, no RF write.
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5. Any other value goes to IDLE on the next clock.
- Memory class: opcode = IR[3:0]; 4'hA = load, 4'hB = store.
- IDLE: when i_run = 1, go to FETCH; otherwise stay.
- FETCH:
  - o_imem_req = 1 and o_imem_addr = pc, held stable until ack.
  - On i_imem_ack, IR <= i_imem_rdata and go to DECODE. Otherwise stay; wait states are unbounded.
- DECODE: one cycle (decoder settles on o_instr), then go to EXEC.
- EXEC: one cycle. Next state:
  - load or store: MEM.
  - otherwise, i_rd_wen = 1: WB.
  - otherwise: retire.
- MEM:
  - o_dmem_req = 1, o_dmem_we = i_mem_wen.
  - On i_dmem_ack: load goes to WB; store retires. Otherwise stay.
- WB: o_rf_we = i_rd_wen for exactly this cycle, then retire.
- Retire (taken on the transition out of EXEC, MEM or WB):
  - o_retire = 1 in the final cycle of the instruction.
  - pc <= pc + PC_STEP, modulo 2^16 (wraps 16'hFFFE -> 16'h0000 with default step).
  - o_retire_cnt <= o_retire_cnt + 1, wrapping at 2^16.
  - Next state is FETCH if i_run = 1, else IDLE.
- Output timing:
  - o_imem_req, o_dmem_req, o_dmem_we and o_rf_we decode combinationally from the registered state and registered IR only. No input-to-output combinational path except o_dmem_we <- i_mem_wen.
  - o_retire is a combinational decode of (state, retire condition).
- Acks outside the matching state are ignored.
- An ack in the first cycle of a request is accepted (zero-wait).
- i_run is sampled only in IDLE and at retire. Deasserting it mid-instruction never truncates the instruction.
- Cycle counts with zero-wait acks, measured FETCH entry to retire:
  - load: 5
  - non-memory with rd write: 4
  - store: 4
  - non-memory without rd write: 3

Test Plan:
- Reset, then i_run = 1, fetch returns 16'h321A (load) with i_imem_ack in the first cycle, i_dmem_ack in the first cycle -> states 1,2,3,4,5; o_dmem_we = 0; o_rf_we pulses once in WB; pc 0 -> 2; o_retire_cnt = 1.
- Store 16'h0F2B, i_mem_wen = 1, i_dmem_ack delayed 3 cycles -> o_dmem_req/o_dmem_we held high 4 cycles; no o_rf_we; retire after 4 + 3 = 7 cycles.
- Fetch with i_imem_ack delayed 5 cycles, i_imem_rdata changing before the ack -> IR captures only the value present on the ack cycle; o_imem_addr stable throughout.
- Drop i_run during MEM -> instruction completes and retires, FSM enters IDLE with pc advanced; o_imem_req stays 0 until i_run = 1 again.
- Assert i_rst_n = 0 mid-MEM with o_dmem_req = 1 -> o_dmem_req falls without a clock edge; pc = PC_RESET; o_retire_cnt = 0; no o_rf_we.
- Preload pc via reset with PC_RESET = 16'hFFFE, retire one non-memory instruction (i_rd_wen = 0) -> 3-cycle instruction, pc wraps to 16'h0000; spurious i_dmem_ack during FETCH is ignored.

Source files
------------

// File: rtl/z16_multicycle_ctrl.sv
// Z16 multi-cycle sequencer: owns PC and IR, runs the FETCH/DECODE/EXEC/MEM/WB
// sequence and drives the instruction/data memory request handshakes.
module z16_multicycle_ctrl #(
   parameter logic [15:0] PC_RESET = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'h0002
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_run,
   output logic        o_imem_req,
   output logic [15:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [15:0] i_imem_rdata,
   output logic [15:0] o_instr,
   input  logic        i_rd_wen,
   input  logic        i_mem_wen,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   input  logic        i_dmem_ack,
   output logic        o_rf_we,
   output logic        o_retire,
   output logic [15:0] o_pc,
   output logic [15:0] o_retire_cnt,
   output logic [2:0]  o_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5
   } state_t;

   state_t      state;
   logic [15:0] pc;
   logic [15:0] ir;
   logic [15:0] retire_cnt;
   logic        rd_wen_q;
   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic        retire;

   // Memory-class decode from the latched opcode and the retire condition per state
   always_comb begin
      is_load  = (ir[3:0] == 4'hA);
      is_store = (ir[3:0] == 4'hB);
      is_mem   = is_load | is_store;
      retire   = 1'b0;
      case (state)
         EXEC:    retire = !is_mem && !i_rd_wen;
         MEM:     retire = is_store && i_dmem_ack;
         WB:      retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   // Sequencer state, PC, IR and retire counter
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         pc         <= PC_RESET;
         ir         <= '0;
         retire_cnt <= '0;
         rd_wen_q   <= 1'b0;
      end else begin
         if (retire) begin
            pc         <= pc + PC_STEP;
            retire_cnt <= retire_cnt + 16'd1;
         end
         case (state)
            IDLE: begin
               if (i_run) state <= FETCH;
            end
            FETCH: begin
               if (i_imem_ack) begin
                  ir    <= i_imem_rdata;
                  state <= DECODE;
               end
            end
            DECODE: begin
               state <= EXEC;
            end
            EXEC: begin
               // rd write-enable is captured here so the WB strobe comes from a register
               rd_wen_q <= i_rd_wen;
               if (is_mem)        state <= MEM;
               else if (i_rd_wen) state <= WB;
               else               state <= i_run ? FETCH : IDLE;
            end
            MEM: begin
               if (i_dmem_ack) begin
                  if (is_load) state <= WB;
                  else         state <= i_run ? FETCH : IDLE;
               end
            end
            WB: begin
               state <= i_run ? FETCH : IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Request strobes decoded from registered state; only the store flag passes through
   always_comb begin
      o_imem_req   = (state == FETCH);
      o_imem_addr  = pc;
      o_dmem_req   = (state == MEM);
      o_dmem_we    = (state == MEM) && i_mem_wen;
      o_rf_we      = (state == WB) && rd_wen_q;
      o_retire     = retire;
      o_instr      = ir;
      o_pc         = pc;
      o_retire_cnt = retire_cnt;
      o_state      = state;
   end

endmodule

// File: tb/tb_z16_multicycle_ctrl.sv
// Directed bench for z16_multicycle_ctrl: walks load, store, delayed fetch,
// run-drop, mid-MEM reset and PC wrap with hand-computed expectations.
module tb_z16_multicycle_ctrl;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        rd_wen;
   logic        mem_wen;
   logic        dmem_ack;

   logic        imem_req, dmem_req, dmem_we, rf_we, retire;
   logic [15:0] imem_addr, instr, pc, retire_cnt;
   logic [2:0]  state;

   logic        w_imem_req, w_dmem_req, w_dmem_we, w_rf_we, w_retire;
   logic [15:0] w_imem_addr, w_instr, w_pc, w_retire_cnt;
   logic [2:0]  w_state;

   int unsigned errors = 0;
   int unsigned checks = 0;

   z16_multicycle_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
      .o_imem_req(imem_req), .o_imem_addr(imem_addr),
      .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
      .o_instr(instr), .i_rd_wen(rd_wen), .i_mem_wen(mem_wen),
      .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .i_dmem_ack(dmem_ack),
      .o_rf_we(rf_we), .o_retire(retire), .o_pc(pc),
      .o_retire_cnt(retire_cnt), .o_state(state)
   );

   z16_multicycle_ctrl #(.PC_RESET(16'hFFFE), .PC_STEP(16'h0002)) dut_wrap (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
      .o_imem_req(w_imem_req), .o_imem_addr(w_imem_addr),
      .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
      .o_instr(w_instr), .i_rd_wen(rd_wen), .i_mem_wen(mem_wen),
      .o_dmem_req(w_dmem_req), .o_dmem_we(w_dmem_we), .i_dmem_ack(dmem_ack),
      .o_rf_we(w_rf_we), .o_retire(w_retire), .o_pc(w_pc),
      .o_retire_cnt(w_retire_cnt), .o_state(w_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      rd_wen = 1'b0; mem_wen = 1'b0; dmem_ack = 1'b0;
      #12;
      check("rst_state", 16'(state), 16'd0);
      check("rst_pc", pc, 16'h0000);
      check("rst_cnt", retire_cnt, 16'd0);
      check("rst_ir", instr, 16'h0000);
      check("rst_imem_req", 16'(imem_req), 16'd0);
      check("rst_dmem_req", 16'(dmem_req), 16'd0);
      check("rst_dmem_we", 16'(dmem_we), 16'd0);
      check("rst_rf_we", 16'(rf_we), 16'd0);
      check("rst_retire", 16'(retire), 16'd0);
      check("rst_wrap_pc", w_pc, 16'hFFFE);
      @(posedge clk);
      #3 rst_n = 1'b1;
      run = 1'b1;
      #1 check("idle_before_edge", 16'(state), 16'd0);

      // load 16'h321A, zero-wait fetch and data ack
      cyc;
      imem_ack = 1'b1; imem_rdata = 16'h321A; rd_wen = 1'b1; mem_wen = 1'b0; dmem_ack = 1'b1;
      #1 check("ld_fetch_state", 16'(state), 16'd1);
      check("ld_imem_req", 16'(imem_req), 16'd1);
      check("ld_imem_addr", imem_addr, 16'h0000);
      cyc; imem_ack = 1'b0;
      #1 check("ld_decode_state", 16'(state), 16'd2);
      check("ld_ir", instr, 16'h321A);
      check("ld_decode_imem_req", 16'(imem_req), 16'd0);
      cyc;
      #1 check("ld_exec_state", 16'(state), 16'd3);
      check("ld_exec_retire", 16'(retire), 16'd0);
      cyc;
      #1 check("ld_mem_state", 16'(state), 16'd4);
      check("ld_dmem_req", 16'(dmem_req), 16'd1);
      check("ld_dmem_we", 16'(dmem_we), 16'd0);
      check("ld_mem_retire", 16'(retire), 16'd0);
      check("ld_mem_rf_we", 16'(rf_we), 16'd0);
      cyc; dmem_ack = 1'b0;
      #1 check("ld_wb_state", 16'(state), 16'd5);
      check("ld_wb_rf_we", 16'(rf_we), 16'd1);
      check("ld_wb_retire", 16'(retire), 16'd1);
      check("ld_wb_dmem_req", 16'(dmem_req), 16'd0);
      cyc;
      #1 check("ld_next_state", 16'(state), 16'd1);
      check("ld_pc", pc, 16'h0002);
      check("ld_cnt", retire_cnt, 16'd1);
      check("ld_rf_we_off", 16'(rf_we), 16'd0);
      check("ld_retire_off", 16'(retire), 16'd0);

      // store 16'h0F2B, data ack delayed 3 cycles
      imem_ack = 1'b1; imem_rdata = 16'h0F2B; rd_wen = 1'b0; mem_wen = 1'b1;
      #1 check("st_imem_addr", imem_addr, 16'h0002);
      cyc; imem_ack = 1'b0;
      #1 check("st_ir", instr, 16'h0F2B);
      cyc;
      #1 check("st_exec_state", 16'(state), 16'd3);
      check("st_exec_retire", 16'(retire), 16'd0);
      cyc;
      for (int i = 0; i < 3; i++) begin
         #1 check("st_wait_state", 16'(state), 16'd4);
         check("st_wait_dmem_req", 16'(dmem_req), 16'd1);
         check("st_wait_dmem_we", 16'(dmem_we), 16'd1);
         check("st_wait_retire", 16'(retire), 16'd0);
         check("st_wait_rf_we", 16'(rf_we), 16'd0);
         cyc;
      end
      dmem_ack = 1'b1;
      #1 check("st_ack_state", 16'(state), 16'd4);
      check("st_ack_dmem_we", 16'(dmem_we), 16'd1);
      check("st_ack_retire", 16'(retire), 16'd1);
      check("st_ack_rf_we", 16'(rf_we), 16'd0);
      cyc; dmem_ack = 1'b0;
      #1 check("st_next_state", 16'(state), 16'd1);
      check("st_pc", pc, 16'h0004);
      check("st_cnt", retire_cnt, 16'd2);

      // fetch with 5 wait cycles and changing read data
      for (int i = 0; i < 5; i++) begin
         imem_rdata = 16'h1110 + 16'(i);
         #1 check("fw_wait_state", 16'(state), 16'd1);
         check("fw_wait_addr", imem_addr, 16'h0004);
         check("fw_wait_req", 16'(imem_req), 16'd1);
         cyc;
      end
      imem_rdata = 16'h0005; imem_ack = 1'b1; rd_wen = 1'b1; mem_wen = 1'b0;
      #1 check("fw_ack_addr", imem_addr, 16'h0004);
      cyc; imem_rdata = 16'hDEAD;
      #1 check("fw_decode_state", 16'(state), 16'd2);
      check("fw_ir", instr, 16'h0005);
      cyc; imem_ack = 1'b0;
      #1 check("fw_exec_state", 16'(state), 16'd3);
      check("fw_ir_hold", instr, 16'h0005);
      cyc;
      #1 check("fw_wb_state", 16'(state), 16'd5);
      check("fw_wb_rf_we", 16'(rf_we), 16'd1);
      check("fw_wb_retire", 16'(retire), 16'd1);
      cyc;
      #1 check("fw_pc", pc, 16'h0006);
      check("fw_cnt", retire_cnt, 16'd3);

      // load with i_run dropped during MEM
      imem_ack = 1'b1; imem_rdata = 16'h004A; rd_wen = 1'b1; mem_wen = 1'b0;
      cyc; imem_ack = 1'b0;
      #1 check("rd_decode_state", 16'(state), 16'd2);
      cyc;
      cyc; run = 1'b0;
      #1 check("rd_mem_state", 16'(state), 16'd4);
      cyc; dmem_ack = 1'b1;
      #1 check("rd_mem_ack_state", 16'(state), 16'd4);
      check("rd_mem_ack_retire", 16'(retire), 16'd0);
      cyc; dmem_ack = 1'b0;
      #1 check("rd_wb_state", 16'(state), 16'd5);
      check("rd_wb_retire", 16'(retire), 16'd1);
      cyc;
      #1 check("rd_idle_state", 16'(state), 16'd0);
      check("rd_pc", pc, 16'h0008);
      check("rd_cnt", retire_cnt, 16'd4);
      check("rd_idle_req", 16'(imem_req), 16'd0);
      cyc; cyc;
      #1 check("rd_park_state", 16'(state), 16'd0);
      check("rd_park_req", 16'(imem_req), 16'd0);
      run = 1'b1;
      cyc;
      #1 check("rd_resume_state", 16'(state), 16'd1);
      check("rd_resume_req", 16'(imem_req), 16'd1);
      check("rd_resume_addr", imem_addr, 16'h0008);

      // store aborted by reset in MEM
      imem_ack = 1'b1; imem_rdata = 16'h007B; rd_wen = 1'b0; mem_wen = 1'b1;
      cyc; imem_ack = 1'b0;
      cyc;
      cyc;
      #1 check("ab_mem_state", 16'(state), 16'd4);
      check("ab_dmem_req", 16'(dmem_req), 16'd1);
      #1 rst_n = 1'b0;
      #1 check("ab_dmem_req_off", 16'(dmem_req), 16'd0);
      check("ab_state", 16'(state), 16'd0);
      check("ab_pc", pc, 16'h0000);
      check("ab_cnt", retire_cnt, 16'd0);
      check("ab_rf_we", 16'(rf_we), 16'd0);
      check("ab_retire", 16'(retire), 16'd0);
      check("ab_wrap_pc", w_pc, 16'hFFFE);
      check("ab_wrap_cnt", w_retire_cnt, 16'd0);

      // PC wrap on PC_RESET=FFFE instance, spurious data ack during fetch
      cyc;
      #1 check("wr_held_state", 16'(w_state), 16'd0);
      rst_n = 1'b1; run = 1'b1; mem_wen = 1'b0; rd_wen = 1'b0; dmem_ack = 1'b1;
      cyc;
      #1 check("wr_fetch_state", 16'(w_state), 16'd1);
      check("wr_fetch_addr", w_imem_addr, 16'hFFFE);
      cyc;
      #1 check("wr_spur_state", 16'(w_state), 16'd1);
      check("wr_spur_retire", 16'(w_retire), 16'd0);
      imem_ack = 1'b1; imem_rdata = 16'h0003;
      cyc; imem_ack = 1'b0;
      #1 check("wr_decode_state", 16'(w_state), 16'd2);
      check("wr_ir", w_instr, 16'h0003);
      cyc;
      #1 check("wr_exec_state", 16'(w_state), 16'd3);
      check("wr_exec_retire", 16'(w_retire), 16'd1);
      check("wr_exec_rf_we", 16'(w_rf_we), 16'd0);
      check("wr_exec_dmem_req", 16'(w_dmem_req), 16'd0);
      cyc; dmem_ack = 1'b0;
      #1 check("wr_pc", w_pc, 16'h0000);
      check("wr_cnt", w_retire_cnt, 16'd1);
      check("wr_next_state", 16'(w_state), 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
